// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus downstream valid/ready byte stream
interface fifo_rd_stream_if #(parameter int DATA_W = 8);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  modport master (input fifo_empty, fifo_data, m_ready, output fifo_rd, m_valid, m_data);
  modport slave (output fifo_empty, fifo_data, m_ready, input fifo_rd, m_valid, m_data);
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO into a valid/ready stream via a 3-entry prefetch buffer; FIFO_RD_STATS_EN adds byte/stall counters
module fifo_rd_stream #(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_rd_stream_if.master       bus,
`ifdef FIFO_RD_STATS_EN
  output logic [15:0]            byte_cnt,
  output logic [15:0]            stall_cnt,
`endif
  output logic [1:0]             occupancy
);
  logic [DATA_W-1:0] mem [3];
  logic [1:0] head, tail;
  logic inflight, rd, valid, pop;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  // Issue rule counts the outstanding read so the buffer can never overflow; m_ready is deliberately absent
  assign rd = !rst && !bus.fifo_empty && ({1'b0, occupancy} + {2'b0, inflight} < 3'd3);
  assign valid = occupancy != 2'd0;
  assign pop = valid && bus.m_ready;
  assign bus.fifo_rd = rd;
  assign bus.m_valid = valid;
  assign bus.m_data = valid ? mem[head] : '0;
  // Pointer, occupancy and in-flight bookkeeping; reset drops any byte still returning from the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= 2'd0;
      tail <= 2'd0;
      occupancy <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd;
      if (inflight) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      occupancy <= (inflight && !pop) ? occupancy + 2'd1 :
                   (!inflight && pop) ? occupancy - 2'd1 : occupancy;
    end
  end
  // Capture the byte returned for last cycle's read at the tail
  always_ff @(posedge clk) begin
    if (inflight) mem[tail] <= bus.fifo_data;
  end
`ifdef FIFO_RD_STATS_EN
  // Delivered-byte counter wraps; stall counter saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (pop) byte_cnt <= byte_cnt + 16'd1;
      if (valid && !bus.m_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream against a behavioural 8-deep FIFO
module tb_fifo_rd_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic [1:0] occupancy;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] byte_cnt, stall_cnt;
`endif
  int tests = 0;
  int fails = 0;
  int rd_pulses = 0;
  logic [7:0] exp_q [$];
  logic [7:0] fmem [8];
  int fcnt = 0;
  int frp = 0;
  int fwp = 0;

  fifo_rd_stream_if #(.DATA_W(8)) bus ();

  fifo_rd_stream #(.DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
`ifdef FIFO_RD_STATS_EN
    .byte_cnt(byte_cnt),
    .stall_cnt(stall_cnt),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data_out valid the cycle after rd, not affected by the adapter's reset
  assign bus.fifo_empty = (fcnt == 0);
  initial bus.fifo_data = 8'd0;
  always @(posedge clk) begin
    if (bus.fifo_rd && fcnt == 0) begin
      fails++;
      $display("FAIL rd_when_empty: fifo_rd=1 required 0");
    end
    if (bus.fifo_rd && fcnt > 0) begin
      bus.fifo_data <= fmem[frp];
      frp <= (frp + 1) % 8;
    end
    if (wr && fcnt < 8) begin
      fmem[fwp] <= wdata;
      fwp <= (fwp + 1) % 8;
    end
    fcnt <= fcnt + ((wr && fcnt < 8) ? 1 : 0) - ((bus.fifo_rd && fcnt > 0) ? 1 : 0);
    if (bus.fifo_rd) rd_pulses <= rd_pulses + 1;
  end

  // Monitor: every accepted byte must match the scoreboard head
  always begin
    @(negedge clk);
    #1;
    if (!rst && bus.m_valid && bus.m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_extra: got %0d expected none", bus.m_data);
      end else begin
        if (bus.m_data !== exp_q[0]) begin
          fails++;
          $display("FAIL stream_data: got %0d expected %0d", bus.m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic write_seq(input logic [7:0] first, input int n, input int step);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr = 1'b1;
      wdata = first + 8'(i * step);
      exp_q.push_back(wdata);
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rd();
    for (int k = 0; k < 10 && !bus.fifo_rd; k++) @(negedge clk);
  endtask

  initial begin
    int r0, lat, bad, run;
    bus.m_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_fifo_rd", int'(bus.fifo_rd), 0);
`ifdef FIFO_RD_STATS_EN
    chk("rst_byte_cnt", int'(byte_cnt), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
`endif
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fifo_rd || bus.m_valid || occupancy != 2'd0 || bus.m_data != 8'd0) bad++;
    end
    chk("idle_activity", bad, 0);

    bus.m_ready = 1'b1;
    r0 = rd_pulses;
    write_seq(8'd42, 1, 0);
    wait_rd();
    chk("first_rd", int'(bus.fifo_rd), 1);
    lat = 0;
    while (!bus.m_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency", lat, 2);
    repeat (3) @(negedge clk);
    chk("first_valid_low", int'(bus.m_valid), 0);
    chk("first_rd_pulses", rd_pulses - r0, 1);

    bus.m_ready = 1'b0;
    r0 = rd_pulses;
    write_seq(8'd30, 8, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_data != 8'd30) bad++;
    end
    chk("bp_rd_pulses", rd_pulses - r0, 3);
    chk("bp_occupancy", int'(occupancy), 3);
    chk("bp_fifo_cnt", fcnt, 5);
    chk("bp_m_data", int'(bus.m_data), 30);
    chk("bp_unstable", bad, 0);
    bus.m_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_valid_low", int'(bus.m_valid), 0);

    pulse_reset();
    bus.m_ready = 1'b0;
    write_seq(8'd55, 8, 0);
    repeat (6) @(negedge clk);
    bus.m_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid) run++;
      else if (run > 0) break;
      @(negedge clk);
    end
    chk("stream_run", run, 8);
`ifdef FIFO_RD_STATS_EN
    chk("stream_byte_cnt", int'(byte_cnt), 8);
`endif

    pulse_reset();
    bus.m_ready = 1'b0;
    write_seq(8'd87, 1, 0);
    for (int k = 0; k < 10 && !bus.m_valid; k++) @(negedge clk);
    chk("stall_valid", int'(bus.m_valid), 1);
    repeat (25) @(negedge clk);
    chk("stall_data_held", int'(bus.m_data), 87);
`ifdef FIFO_RD_STATS_EN
    chk("stall_cnt", int'(stall_cnt), 25);
    chk("stall_byte_cnt_before", int'(byte_cnt), 0);
`endif
    bus.m_ready = 1'b1;
    @(negedge clk);
`ifdef FIFO_RD_STATS_EN
    chk("stall_byte_cnt_after", int'(byte_cnt), 1);
    chk("stall_cnt_frozen", int'(stall_cnt), 25);
`endif
    chk("stall_valid_low", int'(bus.m_valid), 0);

    bus.m_ready = 1'b0;
    write_seq(8'd99, 1, 0);
    wait_rd();
    chk("mid_rd", int'(bus.fifo_rd), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_fifo_rd", int'(bus.fifo_rd), 0);
    chk("mid_m_valid", int'(bus.m_valid), 0);
    chk("mid_m_data", int'(bus.m_data), 0);
    chk("mid_occupancy", int'(occupancy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.m_valid || occupancy != 2'd0 || bus.m_data != 8'd0) bad++;
    end
    chk("mid_no_stale", bad, 0);
    bus.m_ready = 1'b1;
    write_seq(8'd77, 1, 0);
    repeat (6) @(negedge clk);
    chk("mid_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the 8-entry, 8-bit `fifo` block. It drains the FIFO through its `rd`/`empty`/`data_out` port and presents the bytes downstream as a valid/ready stream. A 3-entry prefetch buffer hides the FIFO's one-cycle read latency. The buffer also keeps any combinational path from `m_ready` to `fifo_rd`, so the stream runs at one byte per cycle in steady state. The block sits between `fifo` and any byte consumer, such as a UART TX or a bus bridge.

## Interface
- `DATA_W`, 8, byte width; must match the FIFO data width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid in the cycle after an accepted `fifo_rd`.
- `fifo_rd`  out  1  read strobe to the FIFO `rd` input.
- `m_valid`  out  1  output byte valid.
- `m_data`  out  DATA_W  output byte (head of the prefetch buffer).
- `m_ready`  in  1  downstream accept.
- `occupancy`  out  2  number of bytes held in the prefetch buffer, 0..3.
- `byte_cnt`  out  16  bytes delivered. Present only with `FIFO_RD_STATS_EN`.
- `stall_cnt`  out  16  backpressure cycles. Present only with `FIFO_RD_STATS_EN`.

## Operation
- Prefetch buffer:
  - 3-entry circular buffer with 2-bit head and tail pointers; each pointer wraps 2 -> 0.
  - `occupancy` counts held bytes, 0..3.
- In-flight tracking: a 1-bit `inflight` register is set on every cycle `fifo_rd` is high.
- Read issue:
  - `fifo_rd = !rst && !fifo_empty && (occupancy + inflight < 3)`.
  - The condition uses registered state and `fifo_empty` only; `m_ready` never affects it.
  - The block never reads an empty FIFO.
- Capture: when `inflight` is 1, `fifo_data` is written at the tail and the tail advances. Space is always guaranteed by the issue rule.
- Output:
  - `m_valid = (occupancy != 0)`.
  - `m_data` = head entry; 0 when the buffer is empty.
  - A pop occurs on `m_valid && m_ready`; the head advances.
- Simultaneous capture and pop: `occupancy` is unchanged and both pointers advance.
- Ordering: bytes leave in exactly FIFO order, with no duplication and no loss.
- Backpressure:
  - With `m_ready` low, the buffer fills to 3 and `fifo_rd` stops.
  - The remaining bytes stay in the FIFO, and `fifo_cnt` shows them.
- Reset asserted at any time:
  - Outputs go to their reset values immediately.
  - The buffer and `inflight` are cleared.
  - A byte returned by the FIFO for a pre-reset read is discarded.

## Timing
- Reset values: `fifo_rd`=0, `m_valid`=0, `m_data`=0, `occupancy`=0, `byte_cnt`=0, `stall_cnt`=0.
- Read latency:
  - `fifo_rd` is high in cycle N.
  - `fifo_data` is valid in cycle N+1 and captured at the end of N+1.
  - `m_valid` goes high in cycle N+2.
  - Latency from `fifo_empty` falling to `m_valid` rising is 2 cycles.
- Throughput:
  - With `m_ready` held high and the FIFO non-empty, the stream delivers one byte per cycle after the first.
  - Steady state is `occupancy`=1 and `inflight`=1.
- Handshake:
  - Once `m_valid` is high it stays high, with `m_data` stable, until the byte is accepted.
  - `m_data` changes only after a pop or a capture into an empty buffer.
- `fifo_empty` rising while a read is in flight: the in-flight byte is still captured, and no further reads are issued.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `byte_cnt` increments on every pop and wraps at 16 bits.
  - `stall_cnt` increments on every cycle with `m_valid && !m_ready` and saturates at 0xFFFF.
  - Both counters are cleared by `rst`.
- `FIFO_RD_STATS_EN` undefined: both ports and their registers are absent; all other behaviour is identical.

## Test plan
- Reset and idle: hold `rst` high for 10 cycles, then keep `fifo_empty` at 1 for 20 cycles -> all outputs stay 0 and `fifo_rd` never asserts.
- First byte: write 42 into the FIFO with `m_ready`=1 -> `fifo_rd` pulses one cycle, `m_valid`=1 with `m_data`=42 two cycles later, then `m_valid` returns to 0.
- Backpressure:
  - Write 30, 31, …, 37 (8 bytes) with `m_ready`=0 -> exactly 3 `fifo_rd` pulses, `occupancy`=3, FIFO `fifo_cnt`=5, `m_data`=30 held stable.
  - Then raise `m_ready` -> bytes 30..37 are delivered in order.
- Streaming: write 8 bytes of 55, then hold `m_ready`=1 -> 8 consecutive `m_valid` cycles with no gap after the first; with `FIFO_RD_STATS_EN`, `byte_cnt`=8.
- Stall count: with `FIFO_RD_STATS_EN`, write 87 and hold `m_ready`=0 for 25 cycles after `m_valid` rises -> `stall_cnt`=25, and `byte_cnt` increments by 1 on release.
- Mid-operation reset: assert `rst` in the cycle after a `fifo_rd` pulse -> outputs go to 0 asynchronously, and after release no stale byte appears on `m_data`.
